// File: rtl/stage3_if.sv
// Stage-2 buffer to stage-3 execute link, plus the registered results handed to stage 4.
interface stage3_if #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
);
   logic              in_valid;
   logic [7:0]        in_opcode;
   logic [DATA_W-1:0] in_op1;
   logic [DATA_W-1:0] in_op2;
   logic [PC_W-1:0]   in_pc;
   logic              flush;
   logic              stall;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_result;
   logic [DATA_W-1:0] wb_result_hi;
   logic [PC_W-1:0]   wb_pc;
   logic              branch_taken;
   logic [PC_W-1:0]   branch_target;
   logic              flag_z;
   logic              flag_c;
   logic              illegal_op;

   modport master (
      output in_valid, in_opcode, in_op1, in_op2, in_pc, flush,
      input  stall, wb_valid, wb_result, wb_result_hi, wb_pc,
             branch_taken, branch_target, flag_z, flag_c, illegal_op
   );

   modport slave (
      input  in_valid, in_opcode, in_op1, in_op2, in_pc, flush,
      output stall, wb_valid, wb_result, wb_result_hi, wb_pc,
             branch_taken, branch_target, flag_z, flag_c, illegal_op
   );
endinterface

// File: rtl/stage3_execute.sv
// Stage-3 execute: single-cycle ALU/move/branch ops, iterative shift-add MUL with upstream stall.
module stage3_execute #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
) (
   input logic     clk,
   input logic     rst,
   stage3_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   localparam logic [7:0] OP_NOP = 8'h00;
   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_SUB = 8'h02;
   localparam logic [7:0] OP_AND = 8'h03;
   localparam logic [7:0] OP_OR  = 8'h04;
   localparam logic [7:0] OP_XOR = 8'h05;
   localparam logic [7:0] OP_MUL = 8'h06;
   localparam logic [7:0] OP_MOV = 8'h07;
   localparam logic [7:0] OP_JMP = 8'h08;
   localparam logic [7:0] OP_JZ  = 8'h09;

   typedef enum logic {EXEC, MUL} state_t;

   state_t state, state_n;

   logic [2*DATA_W-1:0] mcand, mcand_n, acc, acc_n, acc_step;
   logic [DATA_W-1:0]   mplier, mplier_n;
   logic [CNT_W-1:0]    count, count_n;
   logic [PC_W-1:0]     mul_pc, mul_pc_n;

   logic              stall_n, wb_valid_n, branch_taken_n, illegal_op_n;
   logic              flag_z_n, flag_c_n;
   logic [DATA_W-1:0] wb_result_n, wb_result_hi_n;
   logic [PC_W-1:0]   wb_pc_n, branch_target_n;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;
   logic              accept, last_step;

   assign accept    = bus.in_valid && !bus.flush;
   assign last_step = (count == CNT_W'(DATA_W - 1));
   assign acc_step  = acc + (mplier[0] ? mcand : '0);
   assign sum       = {1'b0, bus.in_op1} + {1'b0, bus.in_op2};
   assign diff      = bus.in_op1 - bus.in_op2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EXEC;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         EXEC: if (accept && bus.in_opcode == OP_MUL) state_n = MUL;
         MUL:  if (bus.flush || last_step)           state_n = EXEC;
         default: state_n = EXEC;
      endcase
   end

   always_comb begin
      stall_n         = (state_n == MUL);
      wb_valid_n      = 1'b0;
      branch_taken_n  = 1'b0;
      illegal_op_n    = 1'b0;
      wb_result_n     = bus.wb_result;
      wb_result_hi_n  = bus.wb_result_hi;
      wb_pc_n         = bus.wb_pc;
      branch_target_n = bus.branch_target;
      flag_z_n        = bus.flag_z;
      flag_c_n        = bus.flag_c;
      mcand_n         = mcand;
      mplier_n        = mplier;
      acc_n           = acc;
      count_n         = count;
      mul_pc_n        = mul_pc;
      case (state)
         EXEC: begin
            if (accept) begin
               if (bus.in_opcode == OP_MUL) begin
                  mcand_n  = {{DATA_W{1'b0}}, bus.in_op1};
                  mplier_n = bus.in_op2;
                  acc_n    = '0;
                  count_n  = '0;
                  mul_pc_n = bus.in_pc;
               end else begin
                  wb_valid_n     = 1'b1;
                  wb_pc_n        = bus.in_pc;
                  wb_result_n    = '0;
                  wb_result_hi_n = '0;
                  case (bus.in_opcode)
                     OP_NOP: ;
                     OP_ADD: begin
                        wb_result_n = sum[DATA_W-1:0];
                        flag_c_n    = sum[DATA_W];
                        flag_z_n    = (sum[DATA_W-1:0] == '0);
                     end
                     OP_SUB: begin
                        wb_result_n = diff;
                        flag_c_n    = (bus.in_op1 < bus.in_op2);
                        flag_z_n    = (diff == '0);
                     end
                     OP_AND: begin
                        wb_result_n = bus.in_op1 & bus.in_op2;
                        flag_z_n    = ((bus.in_op1 & bus.in_op2) == '0);
                     end
                     OP_OR: begin
                        wb_result_n = bus.in_op1 | bus.in_op2;
                        flag_z_n    = ((bus.in_op1 | bus.in_op2) == '0);
                     end
                     OP_XOR: begin
                        wb_result_n = bus.in_op1 ^ bus.in_op2;
                        flag_z_n    = ((bus.in_op1 ^ bus.in_op2) == '0);
                     end
                     OP_MOV: begin
                        wb_result_n = bus.in_op2;
                        flag_z_n    = (bus.in_op2 == '0);
                     end
                     OP_JMP: begin
                        branch_taken_n  = 1'b1;
                        branch_target_n = PC_W'(bus.in_op1);
                     end
                     OP_JZ: begin
                        // Uses the flag as left by the previous instruction.
                        if (bus.flag_z) begin
                           branch_taken_n  = 1'b1;
                           branch_target_n = PC_W'(bus.in_op1);
                        end
                     end
                     default: illegal_op_n = 1'b1;
                  endcase
               end
            end
         end
         MUL: begin
            if (!bus.flush) begin
               acc_n    = acc_step;
               mcand_n  = mcand << 1;
               mplier_n = mplier >> 1;
               count_n  = count + CNT_W'(1);
               if (last_step) begin
                  wb_valid_n     = 1'b1;
                  wb_result_n    = acc_step[DATA_W-1:0];
                  wb_result_hi_n = acc_step[2*DATA_W-1:DATA_W];
                  wb_pc_n        = mul_pc;
                  flag_z_n       = (acc_step == '0);
                  flag_c_n       = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.stall         <= 1'b0;
         bus.wb_valid      <= 1'b0;
         bus.wb_result     <= '0;
         bus.wb_result_hi  <= '0;
         bus.wb_pc         <= '0;
         bus.branch_taken  <= 1'b0;
         bus.branch_target <= '0;
         bus.flag_z        <= 1'b0;
         bus.flag_c        <= 1'b0;
         bus.illegal_op    <= 1'b0;
         mcand             <= '0;
         mplier            <= '0;
         acc               <= '0;
         count             <= '0;
         mul_pc            <= '0;
      end else begin
         bus.stall         <= stall_n;
         bus.wb_valid      <= wb_valid_n;
         bus.wb_result     <= wb_result_n;
         bus.wb_result_hi  <= wb_result_hi_n;
         bus.wb_pc         <= wb_pc_n;
         bus.branch_taken  <= branch_taken_n;
         bus.branch_target <= branch_target_n;
         bus.flag_z        <= flag_z_n;
         bus.flag_c        <= flag_c_n;
         bus.illegal_op    <= illegal_op_n;
         mcand             <= mcand_n;
         mplier            <= mplier_n;
         acc               <= acc_n;
         count             <= count_n;
         mul_pc            <= mul_pc_n;
      end
   end
endmodule

// File: tb/tb_stage3_execute.sv
// Directed and randomized checks of stage3_execute against an arithmetic reference model.
module tb_stage3_execute;
   localparam int DATA_W = 8;
   localparam int PC_W   = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stage3_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();
   stage3_execute #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int m_res, m_hi, m_pc, m_tgt, m_z, m_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input int wv, input int bt, input int ill, input int st);
      chk("wb_valid",      32'(bus.wb_valid),      32'(wv));
      chk("branch_taken",  32'(bus.branch_taken),  32'(bt));
      chk("illegal_op",    32'(bus.illegal_op),    32'(ill));
      chk("stall",         32'(bus.stall),         32'(st));
      chk("wb_result",     32'(bus.wb_result),     32'(m_res));
      chk("wb_result_hi",  32'(bus.wb_result_hi),  32'(m_hi));
      chk("wb_pc",         32'(bus.wb_pc),         32'(m_pc));
      chk("branch_target", 32'(bus.branch_target), 32'(m_tgt));
      chk("flag_z",        32'(bus.flag_z),        32'(m_z));
      chk("flag_c",        32'(bus.flag_c),        32'(m_c));
   endtask

   task automatic model_reset();
      m_res = 0; m_hi = 0; m_pc = 0; m_tgt = 0; m_z = 0; m_c = 0;
   endtask

   task automatic drive(input int op, input int a, input int b, input int pc, input int fl);
      bus.in_valid  = 1'b1;
      bus.in_opcode = 8'(op);
      bus.in_op1    = 8'(a);
      bus.in_op2    = 8'(b);
      bus.in_pc     = 8'(pc);
      bus.flush     = 1'(fl);
   endtask

   task automatic do_single(input int op, input int a, input int b, input int pc);
      int bt, ill, r;
      drive(op, a, b, pc, 0);
      step();
      bt = 0; ill = 0; r = 0;
      case (op)
         0: ;
         1: begin r = (a + b) & 255; m_c = (a + b > 255) ? 1 : 0; m_z = (r == 0) ? 1 : 0; end
         2: begin r = (a - b) & 255; m_c = (a < b) ? 1 : 0; m_z = (r == 0) ? 1 : 0; end
         3: begin r = a & b; m_z = (r == 0) ? 1 : 0; end
         4: begin r = a | b; m_z = (r == 0) ? 1 : 0; end
         5: begin r = a ^ b; m_z = (r == 0) ? 1 : 0; end
         7: begin r = b;     m_z = (r == 0) ? 1 : 0; end
         8: begin bt = 1; m_tgt = a; end
         9: if (m_z == 1) begin bt = 1; m_tgt = a; end
         default: ill = 1;
      endcase
      m_res = r; m_hi = 0; m_pc = pc;
      check_all(1, bt, ill, 0);
      bus.in_valid = 1'b0;
   endtask

   task automatic do_mul(input int a, input int b, input int pc, input int flush_at);
      int prod;
      drive(6, a, b, pc, 0);
      step();
      check_all(0, 0, 0, 1);
      for (int k = 1; k <= DATA_W; k++) begin
         // Junk on the inputs while busy; it must be ignored.
         drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (k == flush_at) ? 1 : 0);
         step();
         bus.flush = 1'b0;
         if (k == flush_at) begin
            check_all(0, 0, 0, 0);
            bus.in_valid = 1'b0;
            return;
         end
         if (k == DATA_W) begin
            prod  = a * b;
            m_res = prod & 255;
            m_hi  = (prod >> 8) & 255;
            m_pc  = pc;
            m_z   = (prod == 0) ? 1 : 0;
            m_c   = 0;
            check_all(1, 0, 0, 0);
         end else begin
            check_all(0, 0, 0, 1);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flushed(input int op, input int a, input int b, input int pc);
      drive(op, a, b, pc, 1);
      step();
      check_all(0, 0, 0, 0);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      int r, fa;
      bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_op1 = '0;
      bus.in_op2 = '0; bus.in_pc = '0; bus.flush = 1'b0;
      model_reset();
      #2 rst = 1'b1;
      #1 check_all(0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;
      step();
      check_all(0, 0, 0, 0);

      do_single(1, 8'hF0, 8'h20, 8'h10);
      step();
      check_all(0, 0, 0, 0);
      do_single(2, 8'h05, 8'h05, 8'h11);
      do_single(9, 8'h3C, 8'h00, 8'h12);
      do_single(1, 8'h01, 8'h02, 8'h13);
      do_single(9, 8'h77, 8'h00, 8'h14);
      do_single(8, 8'h9A, 8'h00, 8'h15);
      do_single(3, 8'hF0, 8'h0F, 8'h16);
      do_mul(8'hFF, 8'hFF, 8'h20, 0);
      do_mul(8'h12, 8'h34, 8'h21, 4);
      do_mul(8'h5A, 8'hC3, 8'h22, DATA_W);
      do_mul(8'h00, 8'h7E, 8'h23, 0);
      do_single(8'hAB, 8'h11, 8'h22, 8'h24);
      do_flushed(1, 8'hFF, 8'h01, 8'h25);
      do_flushed(6, 8'h03, 8'h04, 8'h26);

      for (int i = 0; i < 80; i++) begin
         r = int'($urandom_range(0, 11));
         if (r == 6) begin
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DATA_W)) : 0;
            do_mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), fa);
         end else if (r == 10) begin
            do_single(int'($urandom_range(10, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         end else if (r == 11) begin
            do_flushed(int'($urandom_range(0, 9)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         end else begin
            do_single(r, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)));
         end
         if ($urandom_range(0, 4) == 0) begin
            step();
            check_all(0, 0, 0, 0);
         end
      end

      drive(6, 8'h33, 8'h44, 8'h50, 0);
      step();
      step();
      step();
      check_all(0, 0, 0, 1);
      #3 rst = 1'b1;
      model_reset();
      #1 check_all(0, 0, 0, 0);
      bus.in_valid = 1'b0;
      step();
      check_all(0, 0, 0, 0);
      rst = 1'b0;
      do_single(1, 8'h01, 8'h01, 8'h60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
